// File: rtl/mailbox_reader_pkg.sv
// Shared constants for the arcade bus mailbox blocks.
//   mbx_state_t    : mailbox reader state encoding (EMPTY, FULL, READING)
//   MBX_DATA_WIDTH : default data byte width
//   MBX_OVR_WIDTH  : default overrun counter width
package mailbox_reader_pkg;

    localparam int MBX_DATA_WIDTH = 8;
    localparam int MBX_OVR_WIDTH  = 4;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FULL    = 2'd1,
        ST_READING = 2'd2
    } mbx_state_t;

endpackage

// File: rtl/mailbox_reader_if.sv
// Mailbox bus bundle: writer strobe/data, reader select, overrun clear,
// and the read-side results.
//   master : the bus owner driving Wr_bar, D, Rd_bar, Clr_ovr
//   slave  : the mailbox, returning Q, Full, Overrun, Ovr_count
// Handshake: Wr_bar and Rd_bar are active-low levels held one or more
// clocks. A write is the Wr_bar high-to-low transition; a read completes
// on the Rd_bar low-to-high transition. Q is stable while Rd_bar is low.
interface mailbox_reader_if #(
    parameter int WIDTH     = 8,
    parameter int OVR_WIDTH = 4
);
    logic                 Wr_bar;
    logic [WIDTH-1:0]     D;
    logic                 Rd_bar;
    logic                 Clr_ovr;
    logic [WIDTH-1:0]     Q;
    logic                 Full;
    logic                 Overrun;
    logic [OVR_WIDTH-1:0] Ovr_count;

    modport master (
        output Wr_bar, D, Rd_bar, Clr_ovr,
        input  Q, Full, Overrun, Ovr_count
    );

    modport slave (
        input  Wr_bar, D, Rd_bar, Clr_ovr,
        output Q, Full, Overrun, Ovr_count
    );
endinterface

// File: rtl/oct_dreg_en.sv
// Enabled D register (octal by default), async active-high reset to zero.
//   clk, rst : clock, asynchronous reset
//   en       : load enable
//   d, q     : data in / registered data out
module oct_dreg_en #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     q <= '0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/strobe_edge.sv
// Edge detector for an active-low strobe.
//   clk, rst  : clock, asynchronous active-high reset
//   strobe    : strobe level (active low)
//   edge_seen : DETECT_FALL=1 -> high-to-low transition (strobe asserted)
//               DETECT_FALL=0 -> low-to-high transition (strobe released)
module strobe_edge #(
    parameter bit DETECT_FALL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic strobe,
    output logic edge_seen
);
    logic hist;
    logic armed;

    // History resets to the inactive level. The armed bit stays clear until
    // the strobe has been observed inactive after reset, so a strobe that is
    // already held low when reset releases never reports an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= 1'b1;
            armed <= 1'b0;
        end else begin
            hist  <= strobe;
            armed <= armed | strobe;
        end
    end

    assign edge_seen = DETECT_FALL ? (armed & hist & ~strobe)
                                   : (armed & ~hist & strobe);
endmodule

// File: rtl/mailbox_reader.sv
// Single-byte mailbox between an asynchronous-style writer and reader.
//   Clk, Reset : clock, asynchronous active-high reset
//   Wr_bar, D  : writer strobe (active low) and data
//   Rd_bar     : reader select (active low)
//   Clr_ovr    : clears Overrun and Ovr_count
//   Q, Full    : data presented to the reader, unread data available
//   Overrun    : sticky lost-data flag; Ovr_count saturating lost-byte count
//   Dbg_state  : current FSM state
module mailbox_reader
    import mailbox_reader_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int OVR_WIDTH = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Wr_bar,
    input  logic [WIDTH-1:0]     D,
    input  logic                 Rd_bar,
    input  logic                 Clr_ovr,
    output logic [WIDTH-1:0]     Q,
    output logic                 Full,
    output logic                 Overrun,
    output logic [OVR_WIDTH-1:0] Ovr_count,
    output mbx_state_t           Dbg_state
);
    mbx_state_t       state, state_n;
    logic             wr_ev, rd_done;
    logic             data_en, pend_en;
    logic [WIDTH-1:0] data_d, data_q, pend_q;
    logic             pend_v, pend_v_n;
    logic             ovr_ev;

    strobe_edge #(.DETECT_FALL(1'b1)) u_wr_edge (
        .clk(Clk), .rst(Reset), .strobe(Wr_bar), .edge_seen(wr_ev)
    );

    strobe_edge #(.DETECT_FALL(1'b0)) u_rd_edge (
        .clk(Clk), .rst(Reset), .strobe(Rd_bar), .edge_seen(rd_done)
    );

    oct_dreg_en #(.WIDTH(WIDTH)) u_data_reg (
        .clk(Clk), .rst(Reset), .en(data_en), .d(data_d), .q(data_q)
    );

    oct_dreg_en #(.WIDTH(WIDTH)) u_pend_reg (
        .clk(Clk), .rst(Reset), .en(pend_en), .d(D), .q(pend_q)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= ST_EMPTY;
            pend_v <= 1'b0;
        end else begin
            state  <= state_n;
            pend_v <= pend_v_n;
        end
    end

    always_comb begin
        state_n  = state;
        data_en  = 1'b0;
        data_d   = D;
        pend_en  = 1'b0;
        pend_v_n = pend_v;
        ovr_ev   = 1'b0;
        case (state)
            ST_EMPTY: begin
                // A completion here is a spurious read and is ignored.
                if (wr_ev) begin
                    data_en = 1'b1;
                    state_n = ST_FULL;
                end
            end
            ST_FULL: begin
                // Unread byte replaced by a new write: the old one is lost.
                if (wr_ev) begin
                    data_en = 1'b1;
                    ovr_ev  = 1'b1;
                end
                if (!Rd_bar) state_n = ST_READING;
            end
            ST_READING: begin
                if (rd_done) begin
                    // Completion resolves first; a coincident write then
                    // lands in the data register and supersedes pending.
                    state_n  = ST_FULL;
                    pend_v_n = 1'b0;
                    if (wr_ev) begin
                        data_en = 1'b1;
                        ovr_ev  = pend_v;
                    end else if (pend_v) begin
                        data_en = 1'b1;
                        data_d  = pend_q;
                    end else begin
                        state_n = ST_EMPTY;
                    end
                end else if (wr_ev) begin
                    // Q stays frozen for the reader; park the byte.
                    pend_en  = 1'b1;
                    pend_v_n = 1'b1;
                    ovr_ev   = pend_v;
                end
            end
            default: state_n = ST_EMPTY;
        endcase
    end

    // An overrun in the same clock as a clear wins and restarts the count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Overrun   <= 1'b0;
            Ovr_count <= '0;
        end else if (ovr_ev) begin
            Overrun <= 1'b1;
            if (Clr_ovr)              Ovr_count <= OVR_WIDTH'(1);
            else if (Ovr_count != '1) Ovr_count <= Ovr_count + OVR_WIDTH'(1);
        end else if (Clr_ovr) begin
            Overrun   <= 1'b0;
            Ovr_count <= '0;
        end
    end

    assign Q         = data_q;
    assign Full      = (state != ST_EMPTY);
    assign Dbg_state = state;
endmodule

// File: tb/tb_mailbox_reader.sv
module tb_mailbox_reader;
    import mailbox_reader_pkg::*;

    logic       Clk;
    logic       Reset;
    mbx_state_t dbg_state;
    int         checks;
    int         errors;

    mailbox_reader_if #(.WIDTH(8), .OVR_WIDTH(4)) bus ();

    mailbox_reader #(.WIDTH(8), .OVR_WIDTH(4)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Wr_bar    (bus.Wr_bar),
        .D         (bus.D),
        .Rd_bar    (bus.Rd_bar),
        .Clr_ovr   (bus.Clr_ovr),
        .Q         (bus.Q),
        .Full      (bus.Full),
        .Overrun   (bus.Overrun),
        .Ovr_count (bus.Ovr_count),
        .Dbg_state (dbg_state)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // driver tasks
    task automatic write_byte(input logic [7:0] d);
        bus.D = d; bus.Wr_bar = 1'b0; tick();
        bus.Wr_bar = 1'b1; tick();
    endtask

    task automatic read_out();
        bus.Rd_bar = 1'b0; tick();
        bus.Rd_bar = 1'b1; tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1; bus.Wr_bar = 1'b1; bus.Rd_bar = 1'b1;
        bus.Clr_ovr = 1'b0; bus.D = 8'h00;
        tick(); tick();
        Reset = 1'b0; tick();
        checks++; if (bus.Q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", bus.Q); end
        checks++; if (bus.Full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.Full); end
        checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", bus.Overrun); end
        checks++; if (bus.Ovr_count !== 4'h0) begin errors++; $display("FAIL reset_cnt: got %h want 0", bus.Ovr_count); end
        checks++; if (dbg_state !== ST_EMPTY) begin errors++; $display("FAIL reset_state: got %0d want EMPTY", dbg_state); end
    endtask

    task automatic test_held_write();
        bus.D = 8'h5A; bus.Wr_bar = 1'b0; tick();
        checks++; if (bus.Q !== 8'h5A) begin errors++; $display("FAIL held_q: got %h want 5a", bus.Q); end
        checks++; if (bus.Full !== 1'b1) begin errors++; $display("FAIL held_full: got %b want 1", bus.Full); end
        bus.D = 8'hA5; tick(); tick();   // still low: must not be a second event
        checks++; if (bus.Q !== 8'h5A) begin errors++; $display("FAIL held_once_q: got %h want 5a", bus.Q); end
        checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL held_ovr: got %b want 0", bus.Overrun); end
        bus.Wr_bar = 1'b1; tick();
        read_out();
        checks++; if (bus.Full !== 1'b0) begin errors++; $display("FAIL held_drain: got %b want 0", bus.Full); end
    endtask

    task automatic test_simple_read();
        write_byte(8'h11);
        bus.Rd_bar = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (bus.Q !== 8'h11 || bus.Full !== 1'b1) begin
                errors++; $display("FAIL read_hold[%0d]: got q=%h full=%b want q=11 full=1", i, bus.Q, bus.Full);
            end
        end
        bus.Rd_bar = 1'b1; tick();
        checks++; if (bus.Full !== 1'b0) begin errors++; $display("FAIL read_done_full: got %b want 0", bus.Full); end
        checks++; if (bus.Q !== 8'h11) begin errors++; $display("FAIL read_done_q: got %h want 11", bus.Q); end
    endtask

    task automatic test_write_during_read();
        write_byte(8'h22);
        bus.Rd_bar = 1'b0; tick();
        bus.D = 8'h33; bus.Wr_bar = 1'b0; tick();
        checks++; if (bus.Q !== 8'h22) begin errors++; $display("FAIL wdr_q_hold: got %h want 22", bus.Q); end
        bus.Wr_bar = 1'b1; tick();
        checks++; if (bus.Q !== 8'h22) begin errors++; $display("FAIL wdr_q_hold2: got %h want 22", bus.Q); end
        bus.Rd_bar = 1'b1; tick();
        checks++; if (bus.Q !== 8'h33 || bus.Full !== 1'b1) begin
            errors++; $display("FAIL wdr_pending: got q=%h full=%b want q=33 full=1", bus.Q, bus.Full);
        end
        checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL wdr_ovr: got %b want 0", bus.Overrun); end
        read_out();
        checks++; if (bus.Full !== 1'b0) begin errors++; $display("FAIL wdr_drain: got %b want 0", bus.Full); end
    endtask

    task automatic test_overrun_saturate();
        for (int i = 1; i <= 18; i++) write_byte(8'(i));
        checks++; if (bus.Q !== 8'h12) begin errors++; $display("FAIL sat_q: got %h want 12", bus.Q); end
        checks++; if (bus.Ovr_count !== 4'hF) begin errors++; $display("FAIL sat_cnt: got %h want f", bus.Ovr_count); end
        checks++; if (bus.Overrun !== 1'b1) begin errors++; $display("FAIL sat_ovr: got %b want 1", bus.Overrun); end
        bus.Clr_ovr = 1'b1; tick(); bus.Clr_ovr = 1'b0;
        checks++; if (bus.Overrun !== 1'b0 || bus.Ovr_count !== 4'h0) begin
            errors++; $display("FAIL clr: got ovr=%b cnt=%h want 0/0", bus.Overrun, bus.Ovr_count);
        end
        // overrun coincident with clear: overrun wins, count restarts at 1
        bus.D = 8'h77; bus.Wr_bar = 1'b0; bus.Clr_ovr = 1'b1; tick();
        bus.Wr_bar = 1'b1; bus.Clr_ovr = 1'b0; tick();
        checks++; if (bus.Overrun !== 1'b1 || bus.Ovr_count !== 4'h1) begin
            errors++; $display("FAIL clr_vs_ovr: got ovr=%b cnt=%h want 1/1", bus.Overrun, bus.Ovr_count);
        end
        bus.Clr_ovr = 1'b1; tick(); bus.Clr_ovr = 1'b0;
        read_out();
        checks++; if (bus.Full !== 1'b0 || bus.Q !== 8'h77) begin
            errors++; $display("FAIL sat_drain: got full=%b q=%h want 0/77", bus.Full, bus.Q);
        end
    endtask

    task automatic test_back_to_back();
        write_byte(8'h30);
        bus.Rd_bar = 1'b0; tick();
        // read completion and write event in the same clock
        bus.Rd_bar = 1'b1; bus.D = 8'h44; bus.Wr_bar = 1'b0; tick();
        bus.Wr_bar = 1'b1;
        checks++; if (bus.Full !== 1'b1 || bus.Q !== 8'h44) begin
            errors++; $display("FAIL b2b: got full=%b q=%h want 1/44", bus.Full, bus.Q);
        end
        checks++; if (bus.Overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr: got %b want 0", bus.Overrun); end
        tick();
        read_out();
        // spurious read in EMPTY: nothing changes
        read_out();
        checks++; if (bus.Full !== 1'b0 || bus.Q !== 8'h44 || dbg_state !== ST_EMPTY) begin
            errors++; $display("FAIL spurious: got full=%b q=%h st=%0d want 0/44/EMPTY", bus.Full, bus.Q, dbg_state);
        end
    endtask

    task automatic test_reset_mid_read();
        write_byte(8'h55);
        bus.Rd_bar = 1'b0; tick();
        bus.D = 8'h66; bus.Wr_bar = 1'b0; tick();
        checks++; if (dbg_state !== ST_READING) begin errors++; $display("FAIL rmr_pre: got %0d want READING", dbg_state); end
        // assert reset between edges: outputs clear without a clock
        #2 Reset = 1'b1; #1;
        checks++; if (bus.Full !== 1'b0 || bus.Q !== 8'h00) begin
            errors++; $display("FAIL rmr_async: got full=%b q=%h want 0/00", bus.Full, bus.Q);
        end
        tick();
        Reset = 1'b0; bus.Rd_bar = 1'b1;
        tick(); tick();   // Wr_bar still low through release
        checks++; if (bus.Full !== 1'b0 || bus.Q !== 8'h00 || bus.Overrun !== 1'b0) begin
            errors++; $display("FAIL rmr_no_event: got full=%b q=%h ovr=%b want 0/00/0", bus.Full, bus.Q, bus.Overrun);
        end
        bus.Wr_bar = 1'b1; tick();
        write_byte(8'h99);
        checks++; if (bus.Full !== 1'b1 || bus.Q !== 8'h99) begin
            errors++; $display("FAIL rmr_recover: got full=%b q=%h want 1/99", bus.Full, bus.Q);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_held_write();
        test_simple_read();
        test_write_during_read();
        test_overrun_saturate();
        test_back_to_back();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mailbox_reader.md
MAILBOX_READER -- requirements
Module: mailbox_reader

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the data byte width.
REQ-002 SHALL have parameter OVR_WIDTH, default 4, the overrun counter width.
REQ-003 SHALL have port Clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port Wr_bar, input, 1, active-low writer strobe (level, held one or more clocks).
REQ-006 SHALL have port D, input, WIDTH, writer data, sampled on the strobe edge.
REQ-007 SHALL have port Rd_bar, input, 1, active-low reader select (level, one or more clocks).
REQ-008 SHALL have port Clr_ovr, input, 1, synchronous pulse clearing Overrun and Ovr_count.
REQ-009 SHALL have port Q, output, WIDTH, read data presented to the reader.
REQ-010 SHALL have port Full, output, 1, unread data available.
REQ-011 SHALL have port Overrun, output, 1, sticky flag set when unread data was lost.
REQ-012 SHALL have port Ovr_count, output, OVR_WIDTH, saturating count of lost bytes.

Function
REQ-013 SHALL detect the write event as Wr_bar high on the previous clock and low on the current clock; a held-low strobe SHALL produce exactly one event.
REQ-014 SHALL detect read completion as Rd_bar low on the previous clock and high on the current clock.
REQ-015 SHALL implement states EMPTY, FULL and READING.
REQ-016 EMPTY + write event -> FULL, with D loaded into the data register the same edge; Q and Full update 1 clock after the falling edge of Wr_bar.
REQ-017 FULL + Rd_bar low -> READING; FULL + write event (Rd_bar high) -> stay FULL, data overwritten, overrun recorded.
REQ-018 READING SHALL hold Q stable until read completion, regardless of write events.
REQ-019 READING + write event -> D stored in a pending register and pending valid set; if pending was already valid it is overwritten and an overrun is recorded.
REQ-020 READING + read completion -> EMPTY when pending is invalid; when pending is valid -> FULL, with pending moved to the data register and pending cleared.
REQ-021 A write event and read completion in the same clock SHALL resolve as completion first, then the write: the new D goes to the data register, state FULL, no overrun.
REQ-022 EMPTY + read completion (a spurious read) SHALL cause no state change; Q keeps its last value.
REQ-023 An overrun SHALL set Overrun and increment Ovr_count, saturating at all-ones.
REQ-024 Clr_ovr SHALL clear Overrun and Ovr_count; an overrun in the same clock SHALL win (Overrun=1, Ovr_count=1).
REQ-025 Full SHALL be 1 in FULL and READING and 0 in EMPTY.

Reset
REQ-026 Reset SHALL asynchronously force EMPTY, Q=0, pending register=0, pending valid=0, Full=0, Overrun=0, Ovr_count=0.
REQ-027 Both edge-detect history registers SHALL reset to 1 (strobes inactive), so a strobe already low at reset release produces no event.
REQ-028 Reset asserted mid-READING SHALL discard data and pending with no overrun recorded.

Structure
REQ-029 The state encoding (EMPTY, FULL, READING) SHALL live in a shared package with the other arcade bus constants.
REQ-030 The falling/rising strobe detection SHALL be one sub-module, strobe_edge, instantiated twice.
REQ-031 The data register and the pending register SHALL each be an instance of the team's octal enabled D register.

Verification
REQ-032 Reset, Wr_bar low 3 clocks with D=0x5A -> Q=0x5A and Full=1 after 1 clock, one event only, Overrun=0.
REQ-033 D=0x11 written, Rd_bar low 4 clocks, then high -> Q=0x11 throughout, Full=0 one clock after Rd_bar rises.
REQ-034 Write 0x22, Rd_bar low, write 0x33 during the read, Rd_bar high -> Q=0x22 during the read, then Q=0x33 and Full=1, Overrun=0.
REQ-035 Write 0x01..0x12 (18 writes) with no reads -> Q=0x12, Ovr_count=0xF (saturated), Overrun=1; Clr_ovr pulse -> both 0.
REQ-036 Write event in the same clock as read completion with D=0x44 -> Full=1, Q=0x44, Overrun=0.
REQ-037 Reset asserted while READING with pending valid, and Wr_bar held low through reset release -> EMPTY, Full=0, Q=0, no write event.
